// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
//   GROUP : bits resolved per pipeline stage (4-bit lookahead block)
//   op_e  : operation select, OP_ADD = 0, OP_SUB = 1 (matches the sub pin)
package cla_pkg;

  localparam int GROUP = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/cla_group.sv
// 4-bit carry-lookahead block, purely combinational.
// Ports:
//   a, b  : group operands (b already inverted by the caller for subtract)
//   ci    : carry into the group LSB
//   s     : group sum
//   co    : carry out of the group MSB
//   cmsb  : carry into the group MSB, used for signed-overflow detection
module cla_group
  import cla_pkg::*;
(
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is expanded in terms of ci directly, so no ripple through c[i].
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s    = p ^ c[GROUP-1:0];
  assign co   = c[GROUP];
  assign cmsb = c[GROUP-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract unit: one 4-bit lookahead group resolved per stage,
// latency NGROUP cycles, one result per cycle, stalls as a whole on backpressure.
// Ports:
//   clk, rst              : rising-edge clock, async active-high reset
//   in_valid / in_ready   : operand handshake (in_ready = pipeline advance)
//   a, b, cin, sub        : operands, carry-in (add only), 1 = subtract
//   out_valid / out_ready : result handshake
//   sum, cout, ovf        : result, MSB carry (1 = no borrow on subtract),
//                           two's-complement overflow
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGROUP = WIDTH / GROUP;

  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             adv;

  assign op       = op_e'(sub);
  assign b_eff    = (op == OP_SUB) ? ~b : b;
  assign c0       = (op == OP_SUB) ? 1'b1 : cin;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Stage k holds: valid, carry out of group k, sum groups 0..k (packed with
  // the newest group on top), and the operand groups not yet processed
  // (shifted down so the next stage always consumes the low GROUP bits).
  for (genvar k = 0; k < NGROUP; k++) begin : stg
    localparam int IW = WIDTH - k * GROUP;
    localparam int SW = (k + 1) * GROUP;

    logic [IW-1:0]    a_in;
    logic [IW-1:0]    b_in;
    logic             c_in;
    logic             v_in;
    logic [GROUP-1:0] gs;
    logic             gco;
    logic             gcm;
    logic             v_q;
    logic             c_q;
    logic [SW-1:0]    s_q;

    if (k == 0) begin : src
      assign a_in = a;
      assign b_in = b_eff;
      assign c_in = c0;
      assign v_in = in_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)      s_q <= '0;
        else if (adv) s_q <= gs;
      end
    end else begin : src
      assign a_in = stg[k-1].ops.a_q;
      assign b_in = stg[k-1].ops.b_q;
      assign c_in = stg[k-1].c_q;
      assign v_in = stg[k-1].v_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)      s_q <= '0;
        else if (adv) s_q <= {gs, stg[k-1].s_q};
      end
    end

    cla_group u_grp (
      .a    (a_in[GROUP-1:0]),
      .b    (b_in[GROUP-1:0]),
      .ci   (c_in),
      .s    (gs),
      .co   (gco),
      .cmsb (gcm)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= gco;
      end
    end

    if (IW > GROUP) begin : ops
      logic [IW-GROUP-1:0] a_q;
      logic [IW-GROUP-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[IW-1:GROUP];
          b_q <= b_in[IW-1:GROUP];
        end
      end
    end

    // Only the top group's MSB carry matters: overflow = carry into MSB ^ carry out.
    if (k == NGROUP - 1) begin : fin
      logic ovf_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)      ovf_q <= 1'b0;
        else if (adv) ovf_q <= gcm ^ gco;
      end
    end else begin : mid
      logic gcm_unused;
      assign gcm_unused = gcm;
    end
  end

  assign out_valid = stg[NGROUP-1].v_q;
  assign sum       = stg[NGROUP-1].s_q;
  assign cout      = stg[NGROUP-1].c_q;
  assign ovf       = stg[NGROUP-1].fin.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, sum16;
  logic        cin16, sub16, cout16, ovf16;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]  a4, b4, sum4;
  logic        cin4, sub4, cout4, ovf4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  pipelined_cla_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One isolated operation on the 16-bit unit; checks latency, result and
  // that out_valid drops once the result is taken.
  task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                       input logic tcin, input logic tsub,
                       input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    a16 = ta; b16 = tb; cin16 = tcin; sub16 = tsub;
    in_valid16 = 1'b1; out_ready16 = 1'b1;
    #1 check({tag, "_rdy"}, in_ready16, 1);
    @(negedge clk);
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_sum"}, sum16, es);
    check({tag, "_cout"}, cout16, ec);
    check({tag, "_ovf"}, ovf16, eo);
    @(negedge clk);
    check({tag, "_drop"}, out_valid16, 0);
  endtask

  logic [15:0] stream_exp [8];

  initial begin
    int tx, rx, seen;
    rst = 1'b1;
    in_valid16 = 0; out_ready16 = 1; a16 = '0; b16 = '0; cin16 = 0; sub16 = 0;
    in_valid4 = 0; out_ready4 = 1; a4 = '0; b4 = '0; cin4 = 0; sub4 = 0;

    // Reset state
    @(negedge clk);
    #1;
    check("rst_ovalid", out_valid16, 0);
    check("rst_sum", sum16, 0);
    check("rst_cout", cout16, 0);
    check("rst_ovf", ovf16, 0);
    check("rst_irdy", in_ready16, 1);
    check("rst_ovalid4", out_valid4, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_irdy", in_ready16, 1);

    // Directed single operations
    run16("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run16("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run16("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run16("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run16("add_cin",   16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, 1'b0);
    run16("add_negov", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    run16("add_grpc",  16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);

    // Eight back-to-back ops, out_ready low in cycles 6..9
    stream_exp[0] = 16'h0101; stream_exp[1] = 16'h1212;
    stream_exp[2] = 16'h2323; stream_exp[3] = 16'h3434;
    stream_exp[4] = 16'h4545; stream_exp[5] = 16'h5656;
    stream_exp[6] = 16'h6767; stream_exp[7] = 16'h7878;
    tx = 0; rx = 0;
    for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
      @(negedge clk);
      out_ready16 = !(cyc >= 6 && cyc <= 9);
      if (tx < 8) begin
        a16 = 16'(tx * 16'h1111); b16 = 16'h0101; cin16 = 0; sub16 = 0;
        in_valid16 = 1'b1;
      end else begin
        in_valid16 = 1'b0;
      end
      #1;
      if (cyc >= 6 && cyc <= 9) begin
        check("stall_irdy", in_ready16, 0);
        check("stall_ovalid", out_valid16, 1);
        check("stall_hold", sum16, stream_exp[2]);
      end
      if (out_valid16 && out_ready16) begin
        check($sformatf("stream_res%0d", rx), sum16, stream_exp[rx]);
        rx++;
      end
      if (in_valid16 && in_ready16) tx++;
    end
    check("stream_count", rx, 8);
    in_valid16 = 1'b0;
    out_ready16 = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid16) seen++;
    end
    check("stream_no_extra", seen, 0);

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a16 = 16'h1111; b16 = 16'h2222; cin16 = 0; sub16 = 0; in_valid16 = 1'b1;
    end
    @(negedge clk);
    in_valid16 = 1'b0;
    @(negedge clk);
    check("inflight_ovalid", out_valid16, 1);
    rst = 1'b1;
    #1;
    check("midrst_ovalid", out_valid16, 0);
    check("midrst_sum", sum16, 0);
    check("midrst_irdy", in_ready16, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid16) seen++;
    end
    check("midrst_no_stale", seen, 0);
    run16("after_rst", 16'h0F00, 16'h0100, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    // WIDTH=4: single-stage, back-to-back random add/sub against a model
    begin
      logic [3:0] es;
      logic       ec, eo;
      int ta, tb, tc, ts, tot, sres, sa, sb;
      es = '0; ec = 0; eo = 0;
      for (int i = 0; i <= 24; i++) begin
        @(negedge clk);
        if (i > 0) begin
          check("w4_valid", out_valid4, 1);
          check("w4_sum", sum4, es);
          check("w4_cout", cout4, ec);
          check("w4_ovf", ovf4, eo);
        end
        if (i < 24) begin
          ta = $urandom_range(0, 15);
          tb = $urandom_range(0, 15);
          tc = $urandom_range(0, 1);
          ts = $urandom_range(0, 1);
          sa = (ta >= 8) ? ta - 16 : ta;
          sb = (tb >= 8) ? tb - 16 : tb;
          if (ts == 1) begin
            tot  = ta + (15 - tb) + 1;
            sres = sa - sb;
          end else begin
            tot  = ta + tb + tc;
            sres = sa + sb + tc;
          end
          es = tot[3:0];
          ec = tot[4];
          eo = (sres > 7) || (sres < -8);
          a4 = ta[3:0]; b4 = tb[3:0]; cin4 = tc[0]; sub4 = ts[0];
          in_valid4 = 1'b1;
        end else begin
          in_valid4 = 1'b0;
        end
      end
      @(negedge clk);
      check("w4_bubble", out_valid4, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
